// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Round-robin arbiter that shares one sprite ROM read port between four
//   character layers. Every cycle, one requesting layer is granted. Its
//   address goes to the ROM in that same cycle. A 2-bit owner tag travels
//   through a ROM_LATENCY-deep pipeline. When the tag leaves the pipeline,
//   the ROM data is registered and returned to that layer with a one-hot
//   rvalid strobe. A new read can start every cycle.
//
// Parameters
//   ROM_LATENCY  ROM read latency in cycles (1..3)
//   ADDR_W       ROM address width
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   frame_start  one-cycle pulse at the start of a frame, sets the pointer to 0
//   req[3:0]     per-layer read request (bit i = layer i+1)
//   addr0..3     ROM index for each layer
//   gnt[3:0]     one-hot grant, combinational
//   rom_rd       ROM read strobe
//   rom_addr     ROM read address (holds its value when idle)
//   rom_data     ROM data, valid ROM_LATENCY cycles after rom_rd
//   rdata        registered return data
//   rvalid[3:0]  one-hot, one-cycle return strobe
//   busy         high while any read is in flight
module sprite_rom_arbiter #(
  parameter int ROM_LATENCY = 1,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [3:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  output logic [3:0]        gnt,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        rdata,
  output logic [3:0]        rvalid,
  output logic              busy
);

  logic [1:0]        ptr;
  logic [1:0]        win_idx;
  logic              win_any;
  logic [ADDR_W-1:0] addr_sel;
  logic [ADDR_W-1:0] addr_q;

  logic [ROM_LATENCY-1:0] pipe_vld;
  logic [1:0]             pipe_tag [ROM_LATENCY];

  // Search the layers in order ptr, ptr+1, ... (mod 4). The first layer
  // with a request set wins.
  always_comb begin : arb_search
    logic [1:0] cand;
    // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
    win_any = 1'b0;
    win_idx = ptr;
    cand    = ptr;
    for (int i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    addr_sel = addr0;
    case (win_idx)
      2'd0: addr_sel = addr0;
      2'd1: addr_sel = addr1;
      2'd2: addr_sel = addr2;
      2'd3: addr_sel = addr3;
      default: addr_sel = addr0;
    endcase
  end

  // Gating with rst_n keeps the ROM port quiet while the block is held in reset.
  assign gnt      = (win_any && rst_n) ? (4'b0001 << win_idx) : 4'b0000;
  assign rom_rd   = |gnt;
  // The address goes straight to the ROM in the grant cycle. In idle cycles
  // the last granted address is held.
  assign rom_addr = rom_rd ? addr_sel : addr_q;
  assign busy     = |pipe_vld;

  // NOTE: sequential state uses non-blocking assignments, so every register samples its pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= 2'd0;
      addr_q <= '0;
    end else begin
      if (frame_start) begin
        ptr <= 2'd0;
      end else if (rom_rd) begin
        ptr <= win_idx + 2'd1;
      end
      if (rom_rd) begin
        addr_q <= addr_sel;
      end
    end
  end

  // Owner-tag pipeline. It lines up with the ROM latency, so the exit stage
  // is valid in the same cycle as the matching rom_data.
  // NOTE: the tag array is small and its reset value is observable, so it is reset like ordinary flops; a large RAM would be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) begin
        pipe_tag[i] <= 2'd0;
      end
    end else begin
      pipe_vld[0] <= rom_rd;
      pipe_tag[0] <= win_idx;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Return stage: data is registered one cycle after it leaves the ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= 8'h00;
      rvalid <= 4'b0000;
    end else if (pipe_vld[ROM_LATENCY-1]) begin
      rdata  <= rom_data;
      rvalid <= 4'b0001 << pipe_tag[ROM_LATENCY-1];
    end else begin
      rvalid <= 4'b0000;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter
//   Drives two instances (ROM_LATENCY=1 and ROM_LATENCY=3) from the same
//   stimulus. Each instance has its own behavioural ROM. The stimulus task
//   checks the grant against hand-computed one-hot values and queues the
//   expected return. Each instance has a monitor that compares its returns
//   against that queue.
module tb_sprite_rom_arbiter;

  typedef struct {
    logic [3:0] tag;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        frame_start;
  logic [3:0]  req;
  logic [15:0] addr0, addr1, addr2, addr3;

  logic [3:0]  gnt1, gnt3, rvalid1, rvalid3;
  logic        rom_rd1, rom_rd3, busy1, busy3;
  logic [15:0] rom_addr1, rom_addr3;
  logic [7:0]  rom_data1, rom_data3, rdata1, rdata3;

  logic [15:0] rom_sh1 [1];
  logic [15:0] rom_sh3 [3];

  exp_t        q1[$];
  exp_t        q3[$];
  logic [7:0]  last1, last3;
  logic [15:0] last_addr;
  int          cyc;
  int          n_checks;
  int          n_fail;

  // ROM contents: data = addr[7:0] ^ addr[15:8] ^ 8'h78. With this,
  // address 16'h0123 returns 8'h5A.
  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h78;
  endfunction

  sprite_rom_arbiter #(.ROM_LATENCY(1), .ADDR_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .gnt(gnt1), .rom_rd(rom_rd1), .rom_addr(rom_addr1), .rom_data(rom_data1),
    .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
  );

  sprite_rom_arbiter #(.ROM_LATENCY(3), .ADDR_W(16)) dut3 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .req(req),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .gnt(gnt3), .rom_rd(rom_rd3), .rom_addr(rom_addr3), .rom_data(rom_data3),
    .rdata(rdata3), .rvalid(rvalid3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ROMs: the address is delayed by the latency, then looked up.
  always @(posedge clk) begin
    rom_sh1[0] <= rom_addr1;
    rom_sh3[0] <= rom_addr3;
    rom_sh3[1] <= rom_sh3[0];
    rom_sh3[2] <= rom_sh3[1];
  end
  assign rom_data1 = rom_fn(rom_sh1[0]);
  assign rom_data3 = rom_fn(rom_sh3[2]);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] addr_of(input logic [3:0] onehot);
    case (onehot)
      4'b0001: return addr0;
      4'b0010: return addr1;
      4'b0100: return addr2;
      default: return addr3;
    endcase
  endfunction

  // One cycle of stimulus. The task is called at posedge+1 and returns at
  // the next posedge+1.
  task automatic step(input logic [3:0] r, input logic fs, input logic [3:0] eg);
    logic [15:0] a;
    req = r;
    frame_start = fs;
    #1;
    check("gnt_lat1", gnt1, eg);
    check("gnt_lat3", gnt3, eg);
    check("rom_rd", rom_rd1, |eg);
    if (eg != 4'b0000) begin
      a = addr_of(eg);
      last_addr = a;
      q1.push_back('{eg, rom_fn(a), cyc + 2});
      q3.push_back('{eg, rom_fn(a), cyc + 4});
    end
    check("rom_addr_lat1", rom_addr1, last_addr);
    check("rom_addr_lat3", rom_addr3, last_addr);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 1'b0, 4'b0000);
  endtask

  // Hold reset for one cycle with all layers requesting. Outputs must stay quiet.
  task automatic do_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    q1.delete();
    q3.delete();
    last1 = 8'h00;
    last3 = 8'h00;
    last_addr = 16'h0000;
    #1;
    check("reset_gnt", {gnt3, gnt1}, 8'h00);
    check("reset_rom_rd", {rom_rd3, rom_rd1}, 2'b00);
    check("reset_rom_addr", rom_addr1, 16'h0000);
    check("reset_busy", {busy3, busy1}, 2'b00);
    check("reset_rvalid", {rvalid3, rvalid1}, 8'h00);
    check("reset_rdata", {rdata3, rdata1}, 16'h0000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Return monitors. Each expected entry has a due cycle. The instance is
  // busy from grant+1 through due-1.
  always @(negedge clk) begin : mon1
    logic eb;
    eb = 1'b0;
    foreach (q1[i]) if (q1[i].due - 1 <= cyc && cyc <= q1[i].due - 1) eb = 1'b1;
    check("busy_lat1", busy1, eb);
    if (q1.size() != 0 && q1[0].due == cyc) begin
      check("rvalid_lat1", rvalid1, q1[0].tag);
      check("rdata_lat1", rdata1, q1[0].data);
      last1 = q1[0].data;
      void'(q1.pop_front());
    end else begin
      check("rvalid_idle_lat1", rvalid1, 4'b0000);
      check("rdata_hold_lat1", rdata1, last1);
    end
  end

  always @(negedge clk) begin : mon3
    logic eb;
    eb = 1'b0;
    foreach (q3[i]) if (q3[i].due - 3 <= cyc && cyc <= q3[i].due - 1) eb = 1'b1;
    check("busy_lat3", busy3, eb);
    if (q3.size() != 0 && q3[0].due == cyc) begin
      check("rvalid_lat3", rvalid3, q3[0].tag);
      check("rdata_lat3", rdata3, q3[0].data);
      last3 = q3[0].data;
      void'(q3.pop_front());
    end else begin
      check("rvalid_idle_lat3", rvalid3, 4'b0000);
      check("rdata_hold_lat3", rdata3, last3);
    end
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    last1 = 8'h00;
    last3 = 8'h00;
    last_addr = 16'h0000;
    rst_n = 1'b0;
    frame_start = 1'b0;
    req = 4'b0000;
    addr0 = 16'h1000;
    addr1 = 16'h2011;
    addr2 = 16'h0123;
    addr3 = 16'h3033;
    @(posedge clk);
    #1;
    do_reset();

    // Single request from layer 3 (bit 2). Its address is 0123, so the ROM returns 5A.
    check("rom_model_0123", rom_fn(addr2), 8'h5A);
    step(4'b0100, 1'b0, 4'b0100);
    // Idle: no grant, address and data hold.
    idle(5);

    // Full contention starting from reset.
    do_reset();
    for (int i = 0; i < 8; i++) step(4'b1111, 1'b0, 4'b0001 << (i % 4));
    idle(4);

    // Frame restart: move ptr to 2, then pulse frame_start with all requesting.
    step(4'b0010, 1'b0, 4'b0010);
    step(4'b1111, 1'b1, 4'b0100);
    step(4'b1111, 1'b0, 4'b0001);
    // frame_start alone resets the pointer to 0.
    step(4'b0000, 1'b1, 4'b0000);

    // Fairness: layer 4 holds its request while layer 1 toggles.
    step(4'b1001, 1'b0, 4'b0001);
    step(4'b1000, 1'b0, 4'b1000);
    step(4'b1001, 1'b0, 4'b0001);
    step(4'b1000, 1'b0, 4'b1000);
    idle(4);

    // Reset with three reads in flight in the latency-3 instance.
    step(4'b1111, 1'b0, 4'b0001);
    step(4'b1111, 1'b0, 4'b0010);
    step(4'b1111, 1'b0, 4'b0100);
    req = 4'b0000;
    check("busy_before_reset", busy3, 1'b1);
    do_reset();
    idle(5);
    // The first cycle after release arbitrates with ptr=0.
    step(4'b1110, 1'b0, 4'b0010);
    idle(5);

    check("queue_drained_lat1", q1.size(), 0);
    check("queue_drained_lat3", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 The block SHALL have parameter ROM_LATENCY, default 1, the sprite ROM read latency in cycles (legal values 1..3).
REQ-002 The block SHALL have parameter ADDR_W, default 16, the sprite ROM address width.
REQ-003 clk  input  1  single system clock; all state SHALL be on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 frame_start  input  1  one-cycle pulse at the start of each video frame.
REQ-006 req  input  4  per-layer read request; bit i belongs to character layer i+1.
REQ-007 addr0, addr1, addr2, addr3  input  ADDR_W each  sprite ROM index for layers 1..4.
REQ-008 gnt  output  4  one-hot grant, combinational, same cycle as the ROM read it launches.
REQ-009 rom_rd  output  1  ROM read strobe.
REQ-010 rom_addr  output  ADDR_W  ROM read address.
REQ-011 rom_data  input  8  ROM read data, valid ROM_LATENCY cycles after rom_rd.
REQ-012 rdata  output  8  registered read data returned to the requester.
REQ-013 rvalid  output  4  one-hot, one-cycle return strobe; the set bit identifies the owning layer.
REQ-014 busy  output  1  high while any read is in flight.

Function
REQ-015 In each cycle with req nonzero and rst_n high, exactly one gnt bit SHALL be set; with req zero, gnt SHALL be 0.
REQ-016 Arbitration SHALL be round-robin: the search starts at pointer ptr (2 bits) and proceeds ptr, ptr+1, ... modulo 4; the first set req bit wins.
REQ-017 On each grant of layer k, ptr SHALL update to (k+1) mod 4 at the next edge; without a grant, ptr SHALL hold.
REQ-018 frame_start SHALL set ptr to 0 at the next edge, overriding the REQ-017 update; if frame_start coincides with a request, that cycle's grant SHALL use the old ptr.
REQ-019 rom_rd SHALL equal the OR of gnt; rom_addr SHALL equal addr of the granted layer, and SHALL hold its previous value when no grant is given.
REQ-020 A requester holds req and its addr stable until it sees gnt; holding req after gnt SHALL be treated as a new request.
REQ-021 Each grant SHALL push a 2-bit tag through a ROM_LATENCY-deep valid/tag shift pipeline; one read per cycle SHALL be sustained with no bubbles.
REQ-022 When a tag exits the pipeline, at the next edge rdata SHALL take rom_data and rvalid SHALL assert for the tag's bit only; total gnt-to-rvalid latency SHALL be ROM_LATENCY+1 cycles.
REQ-023 When no tag exits, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-024 busy SHALL be high iff any pipeline valid stage is set.
REQ-025 A continuously held request SHALL be granted within 4 cycles of assertion under any pattern of the other requests.
REQ-026 frame_start SHALL NOT cancel in-flight reads; they SHALL complete per REQ-022.
REQ-027 Address arithmetic SHALL NOT be performed; addresses SHALL pass through unmodified at ADDR_W bits.

Reset
REQ-028 While rst_n is low, gnt and rom_rd SHALL be 0 and all registers SHALL reset asynchronously: ptr=0, pipeline valids=0, tags=0, rdata=8'h00, rvalid=4'b0000, rom_addr=0, busy=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight reads; no rvalid SHALL appear for them after reset release.
REQ-030 The first edge after rst_n rises SHALL arbitrate normally with ptr=0.

Verification
REQ-031 Single request: ROM_LATENCY=1, req=4'b0100, addr2=16'h0123, ROM returns 8'h5A -> gnt=4'b0100 and rom_addr=16'h0123 in cycle 0, rvalid=4'b0100 with rdata=8'h5A in cycle 2.
REQ-032 Full contention: req=4'b1111 held for 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; rvalid follows the same order, delayed by 2 cycles, with no gaps.
REQ-033 Frame restart: ptr=2 with frame_start pulsed and req=4'b1111 -> that cycle grants layer 2, the next cycle grants layer 0.
REQ-034 Fairness: req[3] held while req[0] toggles every cycle -> layer 3 is granted within 4 cycles.
REQ-035 Reset mid-flight: ROM_LATENCY=3 with 3 reads outstanding and rst_n pulsed low -> busy=0 and rvalid=0 immediately; no rvalid after release.
REQ-036 Idle: req=0 -> gnt=0, rom_rd=0, rom_addr and rdata unchanged.
